timeout_rpt: RTL and testbench
==============================

Name: timeout_rpt

Overview:
- Event reporter that sits downstream of the per-row enable/mark timeout table.
- On each row check it accepts the row's 16-bit timeout-mark vector and buffers it.
- It then serializes every set bit into single (row, col) timeout events on a valid/ready stream toward the entry-reclaim logic.
- It is the encoder counterpart of the one-hot column select/decode used when the table is written.

Parameters:
- NCOL, 16, columns per row (mark vector width); power of two.
- NROW, 16, number of rows; ROW_W = $clog2(NROW).
- DEPTH, 2, capture FIFO entries (2..4).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- chk_vld  in  1  row-check capture valid.
- chk_rdy  out  1  capture ready; equals "FIFO not full".
- chk_row  in  ROW_W  row index being checked.
- chk_mrk  in  NCOL  timeout-mark vector for that row.
- evt_vld  out  1  timeout event valid.
- evt_rdy  in  1  consumer ready.
- evt_row  out  ROW_W  row of the timed-out entry.
- evt_col  out  $clog2(NCOL)  column of the timed-out entry.
- evt_last  out  1  last event for the current row vector.
- busy  out  1  FIFO non-empty or FSM in SCAN.

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO emptied, FSM to IDLE, work registers cleared.
  - evt_vld=0, evt_row=0, evt_col=0, evt_last=0, busy=0, chk_rdy=1.
  - Pending events are lost when reset asserts mid-operation.
- Capture:
  - Handshake is chk_vld&&chk_rdy.
  - If chk_mrk is nonzero, {chk_row, chk_mrk} is pushed.
  - If chk_mrk is zero, the handshake completes but nothing is pushed, no event is produced, and there is no state change.
  - chk_rdy depends only on FIFO occupancy; there is no pass-through path when full.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head into work_row/work_mrk and go to SCAN.
- FSM SCAN:
  - evt_vld=1.
  - evt_col = index of the lowest set bit of work_mrk.
  - evt_row = work_row.
  - evt_last = (work_mrk has exactly one bit set).
- Event handshake (evt_vld&&evt_rdy):
  - Clear the reported bit in work_mrk.
  - If evt_last is high and the FIFO is non-empty: pop the next entry in the same edge and stay in SCAN (zero bubble between rows).
  - If evt_last is high and the FIFO is empty: go to IDLE.
- Stall: while evt_vld&&!evt_rdy, evt_row, evt_col and evt_last are held stable.
- Latency:
  - chk handshake at edge N gives evt_vld high after edge N+1 (FIFO write at N, load at N+1).
  - Sustained throughput is 1 event/cycle.
- Simultaneous push and pop in the same cycle are both honoured; occupancy is unchanged.
- A row with k set bits yields exactly k events, ascending column order, evt_last on the k-th.
- The same row may appear in the FIFO twice; each occurrence is reported independently, with no merging.

Optional Feature:
- Macro: TIMEOUT_RPT_CNT_EN.
- Defined:
  - Adds output evt_cnt [15:0], reset 0.
  - Increments on every evt handshake and saturates at 16'hFFFF.
  - Adds input cnt_clr [1]; cnt_clr=1 zeroes evt_cnt next edge, with priority over increment.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- timeout_rpt_pkg:
  - NCOL/NROW defaults and ROW_W/COL_W localparams.
  - typedef struct {row, mrk} rpt_ent_t.
  - typedef enum {IDLE, SCAN} rpt_st_e.
  - function lowest-set-bit encoder returning COL_W.
- One sub-module: timeout_rpt_fifo.
  - DEPTH-entry synchronous FIFO of rpt_ent_t.
  - Ports push/pop/full/empty/head.
  - Asynchronous active-low reset.

Test Plan:
- Reset then chk row=3, mrk=16'h8001 with evt_rdy=1:
  - Events (3,0,last=0) then (3,15,last=1).
  - evt_vld first high 2 cycles after capture; busy returns 0 after.
- chk mrk=16'h0000 row=5: handshake completes; evt_vld and busy stay 0.
- evt_rdy=0 for 4 cycles on mrk=16'h0006 row=2: (2,1) held stable, then (2,2,last) after evt_rdy=1.
- Back-to-back rows 1 (mrk 16'h0010) and 7 (mrk 16'hFFFF), evt_rdy=1:
  - 17 consecutive events with no bubble; the row-7 columns run 0..15.
- Overflow with evt_rdy=0 (DEPTH=2):
  - After 3 nonzero captures (1 in work, 2 in FIFO), chk_rdy=0.
  - One evt_last handshake re-asserts chk_rdy next cycle.
- Reset asserted mid-SCAN of mrk=16'h00FF after 3 events:
  - Outputs zero immediately.
  - After release, no further events and chk_rdy=1.
  - With TIMEOUT_RPT_CNT_EN: evt_cnt=0.

Source files
------------

// File: rtl/timeout_rpt_pkg.sv
// Shared types for the timeout event reporter: table geometry, the buffered
// row entry, the scan FSM states and the lowest-set-bit encoder.
package timeout_rpt_pkg;

  localparam int NCOL  = 16;
  localparam int NROW  = 16;
  localparam int ROW_W = $clog2(NROW);
  localparam int COL_W = $clog2(NCOL);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [NCOL-1:0]  mrk;
  } rpt_ent_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } rpt_st_e;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [COL_W-1:0] lsb_enc(input logic [NCOL-1:0] v);
    lsb_enc = '0;
    for (int i = NCOL - 1; i >= 0; i--)
      if (v[i]) lsb_enc = COL_W'(i);
  endfunction

endpackage

// File: rtl/timeout_rpt_fifo.sv
// DEPTH-entry capture FIFO of row/mark entries. Head is combinational from
// storage; push is ignored when full and pop when empty.
module timeout_rpt_fifo
  import timeout_rpt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  rpt_ent_t din,
  input  logic     pop,
  output rpt_ent_t head,
  output logic     full,
  output logic     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rpt_ent_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer wrap that works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; push and pop may both happen in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/timeout_rpt.sv
// Timeout event reporter: buffers nonzero row mark vectors and serializes each
// set bit into a (row, col) event, ascending column order, one per cycle.
// Optional event counter (evt_cnt, cnt_clr) enabled by TIMEOUT_RPT_CNT_EN.
module timeout_rpt
  import timeout_rpt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_vld,
  output logic             chk_rdy,
  input  logic [ROW_W-1:0] chk_row,
  input  logic [NCOL-1:0]  chk_mrk,
  output logic             evt_vld,
  input  logic             evt_rdy,
  output logic [ROW_W-1:0] evt_row,
  output logic [COL_W-1:0] evt_col,
  output logic             evt_last,
  output logic             busy
`ifdef TIMEOUT_RPT_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [15:0]      evt_cnt
`endif
);

  rpt_st_e          st, st_nxt;
  rpt_ent_t         head, din;
  logic             full, empty, push, pop, evt_hs, one_bit;
  logic [ROW_W-1:0] work_row;
  logic [NCOL-1:0]  work_mrk;

  // All-zero vectors complete the handshake but are never buffered.
  assign chk_rdy = !full;
  assign push    = chk_vld && chk_rdy && (chk_mrk != '0);
  assign din     = '{row: chk_row, mrk: chk_mrk};

  timeout_rpt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // work_mrk is never zero in SCAN, so v & (v-1) == 0 means exactly one bit.
  assign one_bit  = ((work_mrk & (work_mrk - 1'b1)) == '0);
  assign evt_vld  = (st == SCAN);
  assign evt_row  = evt_vld ? work_row : '0;
  assign evt_col  = evt_vld ? lsb_enc(work_mrk) : '0;
  assign evt_last = evt_vld && one_bit;
  assign evt_hs   = evt_vld && evt_rdy;
  assign busy     = !empty || evt_vld;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next state and pop; the last event of a row pops the next row in the same
  // edge so consecutive rows stream without a bubble.
  always_comb begin
    st_nxt = st;
    pop    = 1'b0;
    case (st)
      IDLE: if (!empty) begin
        pop    = 1'b1;
        st_nxt = SCAN;
      end
      SCAN: if (evt_hs && evt_last) begin
        if (!empty) pop = 1'b1;
        else        st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Work row: load on pop, otherwise strip the reported (lowest) bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_row <= '0;
      work_mrk <= '0;
    end else if (pop) begin
      work_row <= head.row;
      work_mrk <= head.mrk;
    end else if (evt_hs) begin
      work_mrk <= work_mrk & (work_mrk - 1'b1);
    end
  end

`ifdef TIMEOUT_RPT_CNT_EN
  // Saturating event counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            evt_cnt <= '0;
    else if (cnt_clr)                      evt_cnt <= '0;
    else if (evt_hs && evt_cnt != 16'hFFFF) evt_cnt <= evt_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_timeout_rpt.sv
// Bench for timeout_rpt: directed scenario tasks plus a randomized run, with an
// event scoreboard built from each captured mark vector's set bits.
module tb_timeout_rpt;
  import timeout_rpt_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             chk_vld = 1'b0;
  logic             chk_rdy;
  logic [ROW_W-1:0] chk_row = '0;
  logic [NCOL-1:0]  chk_mrk = '0;
  logic             evt_vld;
  logic             evt_rdy = 1'b0;
  logic [ROW_W-1:0] evt_row;
  logic [COL_W-1:0] evt_col;
  logic             evt_last;
  logic             busy;
`ifdef TIMEOUT_RPT_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [15:0]      evt_cnt;
  logic [15:0]      mdl_cnt = '0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  timeout_rpt #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chk_vld  (chk_vld),
    .chk_rdy  (chk_rdy),
    .chk_row  (chk_row),
    .chk_mrk  (chk_mrk),
    .evt_vld  (evt_vld),
    .evt_rdy  (evt_rdy),
    .evt_row  (evt_row),
    .evt_col  (evt_col),
    .evt_last (evt_last),
    .busy     (busy)
`ifdef TIMEOUT_RPT_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .evt_cnt  (evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every captured nonzero vector expands into one event per set
  // bit, ascending, last flag on the highest bit; reset discards pending ones.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
`ifdef TIMEOUT_RPT_CNT_EN
      mdl_cnt = '0;
`endif
    end else begin
`ifdef TIMEOUT_RPT_CNT_EN
      n_chk++;
      if (evt_cnt !== mdl_cnt) begin
        n_fail++;
        $display("FAIL evt_cnt: got %0d want %0d", evt_cnt, mdl_cnt);
      end
      if (cnt_clr) mdl_cnt = '0;
      else if (evt_vld && evt_rdy && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
`endif
      if (evt_vld && evt_rdy) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL evt_unexpected: got row=%0d col=%0d last=%0b want none",
                   evt_row, evt_col, evt_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (evt_row !== mon_e.row || evt_col !== mon_e.col || evt_last !== mon_e.last) begin
            n_fail++;
            $display("FAIL evt_stream: got row=%0d col=%0d last=%0b want row=%0d col=%0d last=%0b",
                     evt_row, evt_col, evt_last, mon_e.row, mon_e.col, mon_e.last);
          end
        end
      end
      if (chk_vld && chk_rdy)
        for (int c = 0; c < NCOL; c++)
          if (chk_mrk[c]) begin
            mon_e.row  = chk_row;
            mon_e.col  = COL_W'(c);
            mon_e.last = ((chk_mrk >> (c + 1)) == '0);
            exp_q.push_back(mon_e);
          end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    chk_vld = 1'b0;
    evt_rdy = 1'b1;
    for (int i = 0; i < 300 && busy; i++) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset;
    #2;
    n_chk++;
    if ({evt_vld, evt_row, evt_col, evt_last, busy, chk_rdy} !== {1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%0b row=%0d col=%0d last=%0b busy=%0b rdy=%0b want 0,0,0,0,0,1",
               evt_vld, evt_row, evt_col, evt_last, busy, chk_rdy);
    end
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    evt_rdy = 1'b1;
    chk_vld = 1'b1; chk_row = 4'd3; chk_mrk = 16'h8001;
    tick();
    chk_vld = 1'b0;
    n_chk++;
    if (evt_vld !== 1'b0) begin
      n_fail++; $display("FAIL basic_lat1: evt_vld=%0b want 0", evt_vld);
    end
    tick();
    n_chk++;
    if ({evt_vld, evt_row, evt_col, evt_last} !== {1'b1, 4'd3, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL basic_ev0: vld=%0b row=%0d col=%0d last=%0b want 1,3,0,0",
                         evt_vld, evt_row, evt_col, evt_last);
    end
    tick();
    n_chk++;
    if ({evt_vld, evt_row, evt_col, evt_last} !== {1'b1, 4'd3, 4'd15, 1'b1}) begin
      n_fail++; $display("FAIL basic_ev1: vld=%0b row=%0d col=%0d last=%0b want 1,3,15,1",
                         evt_vld, evt_row, evt_col, evt_last);
    end
    tick();
    n_chk++;
    if (evt_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: vld=%0b busy=%0b want 0,0", evt_vld, busy);
    end
  endtask

  task automatic test_zero;
    evt_rdy = 1'b1;
    chk_vld = 1'b1; chk_row = 4'd5; chk_mrk = 16'h0000;
    n_chk++;
    if (chk_rdy !== 1'b1) begin
      n_fail++; $display("FAIL zero_rdy: chk_rdy=%0b want 1", chk_rdy);
    end
    tick();
    chk_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (evt_vld !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL zero_quiet: vld=%0b busy=%0b want 0,0", evt_vld, busy);
      end
      tick();
    end
  endtask

  task automatic test_stall;
    evt_rdy = 1'b0;
    chk_vld = 1'b1; chk_row = 4'd2; chk_mrk = 16'h0006;
    tick();
    chk_vld = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({evt_vld, evt_row, evt_col, evt_last} !== {1'b1, 4'd2, 4'd1, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold: vld=%0b row=%0d col=%0d last=%0b want 1,2,1,0",
                           evt_vld, evt_row, evt_col, evt_last);
      end
      tick();
    end
    evt_rdy = 1'b1;
    tick();
    n_chk++;
    if ({evt_vld, evt_row, evt_col, evt_last} !== {1'b1, 4'd2, 4'd2, 1'b1}) begin
      n_fail++; $display("FAIL stall_next: vld=%0b row=%0d col=%0d last=%0b want 1,2,2,1",
                         evt_vld, evt_row, evt_col, evt_last);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    evt_rdy = 1'b1;
    chk_vld = 1'b1; chk_row = 4'd1; chk_mrk = 16'h0010;
    tick();
    chk_row = 4'd7; chk_mrk = 16'hFFFF;
    tick();
    chk_vld = 1'b0;
    for (int i = 0; i < 17; i++) begin
      n_chk++;
      if (i == 0) begin
        if ({evt_vld, evt_row, evt_col, evt_last} !== {1'b1, 4'd1, 4'd4, 1'b1}) begin
          n_fail++; $display("FAIL b2b_row1: vld=%0b row=%0d col=%0d last=%0b want 1,1,4,1",
                             evt_vld, evt_row, evt_col, evt_last);
        end
      end else if (evt_vld !== 1'b1 || evt_row !== 4'd7 || evt_col !== COL_W'(i - 1)) begin
        n_fail++; $display("FAIL b2b_row7: vld=%0b row=%0d col=%0d want 1,7,%0d",
                           evt_vld, evt_row, evt_col, i - 1);
      end
      tick();
    end
    n_chk++;
    if (evt_vld !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: evt_vld=%0b want 0", evt_vld);
    end
  endtask

  task automatic test_overflow;
    logic [ROW_W-1:0] rows [3];
    logic [NCOL-1:0]  mrks [3];
    rows = '{4'd4, 4'd9, 4'd11};
    mrks = '{16'h0100, 16'h0003, 16'h8000};
    evt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_vld = 1'b1; chk_row = rows[i]; chk_mrk = mrks[i];
      n_chk++;
      if (chk_rdy !== 1'b1) begin
        n_fail++; $display("FAIL ovf_rdy_%0d: chk_rdy=%0b want 1", i, chk_rdy);
      end
      tick();
    end
    chk_row = 4'd13; chk_mrk = 16'h0F00;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (chk_rdy !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL ovf_full: chk_rdy=%0b busy=%0b want 0,1", chk_rdy, busy);
      end
      tick();
    end
    chk_vld = 1'b0;
    evt_rdy = 1'b1;
    tick();
    evt_rdy = 1'b0;
    n_chk++;
    if (chk_rdy !== 1'b1) begin
      n_fail++; $display("FAIL ovf_reopen: chk_rdy=%0b want 1", chk_rdy);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    evt_rdy = 1'b1;
    chk_vld = 1'b1; chk_row = 4'd6; chk_mrk = 16'h00FF;
    tick();
    chk_vld = 1'b0;
    tick();
    tick(); tick(); tick();
    n_chk++;
    if ({evt_vld, evt_col} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL rmid_pre: vld=%0b col=%0d want 1,3", evt_vld, evt_col);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({evt_vld, evt_row, evt_col, evt_last, busy, chk_rdy} !== {1'b1 ^ 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rmid_zero: vld=%0b row=%0d col=%0d last=%0b busy=%0b rdy=%0b want 0,0,0,0,0,1",
                         evt_vld, evt_row, evt_col, evt_last, busy, chk_rdy);
    end
`ifdef TIMEOUT_RPT_CNT_EN
    n_chk++;
    if (evt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rmid_cnt: evt_cnt=%0d want 0", evt_cnt);
    end
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (evt_vld !== 1'b0 || chk_rdy !== 1'b1) begin
        n_fail++; $display("FAIL rmid_after: vld=%0b rdy=%0b want 0,1", evt_vld, chk_rdy);
      end
      tick();
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      chk_vld = ($urandom_range(0, 2) == 0);
      chk_row = ROW_W'($urandom_range(0, NROW - 1));
      chk_mrk = ($urandom_range(0, 4) == 0) ? '0 : NCOL'($urandom & $urandom);
      evt_rdy = ($urandom_range(0, 3) != 0);
`ifdef TIMEOUT_RPT_CNT_EN
      cnt_clr = ($urandom_range(0, 40) == 0);
`endif
      tick();
    end
`ifdef TIMEOUT_RPT_CNT_EN
    cnt_clr = 1'b0;
`endif
    drain();
    tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_leftover: %0d events missing want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
